// File: rtl/booth_mul_seq_16.sv
// booth_mul_seq_16: sequential signed radix-2 Booth multiplier, one step per clock.
// Define BOOTH_MUL_EARLY_EXIT_EN to finish early once all remaining steps are pure shifts.
module booth_mul_seq_16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cancel,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [WIDTH-1:0]     y_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state, w_state_nx;
    logic [WIDTH:0]     r_acc, w_acc_nx;
    logic [WIDTH-1:0]   r_m, w_m_nx;
    logic [WIDTH-1:0]   r_q, w_q_nx;
    logic               r_qm1, w_qm1_nx;
    logic [CW-1:0]      r_cnt, w_cnt_nx;
    logic [2*WIDTH-1:0] r_prod, w_prod_nx;
    logic [WIDTH:0]     w_sm, w_sum;
    logic [2*WIDTH+1:0] w_step;
    logic               w_accept;

    // acc is one bit wider than M so -2^(WIDTH-1) can be negated without overflow
    assign w_sm   = {r_m[WIDTH-1], r_m};
    assign w_sum  = ({r_q[0], r_qm1} == 2'b01) ? r_acc + w_sm :
                    ({r_q[0], r_qm1} == 2'b10) ? r_acc - w_sm : r_acc;
    assign w_step = {w_sum[WIDTH], w_sum, r_q};

`ifdef BOOTH_MUL_EARLY_EXIT_EN
    logic [WIDTH-1:0]   w_mask;
    logic               w_exit;
    logic [2*WIDTH+1:0] w_jump;

    // remaining steps are shift-only when Q[count-1:0] all match q_m1
    assign w_mask = ~({WIDTH{1'b1}} << r_cnt);
    assign w_exit = ~|((r_q ^ {WIDTH{r_qm1}}) & w_mask);
    assign w_jump = $signed({r_acc, r_q, r_qm1}) >>> r_cnt;
`endif

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign product = r_prod;

    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_m_nx     = r_m;
        w_q_nx     = r_q;
        w_qm1_nx   = r_qm1;
        w_cnt_nx   = r_cnt;
        w_prod_nx  = r_prod;
        w_accept   = start && !cancel && (r_state != RUN);
        if (w_accept) begin
            w_state_nx = RUN;
            w_m_nx     = x_in;
            w_q_nx     = y_in;
            w_acc_nx   = '0;
            w_qm1_nx   = 1'b0;
            w_cnt_nx   = CW'(WIDTH);
        end else if (r_state == RUN) begin
            if (cancel) begin
                w_state_nx = IDLE;
            end
`ifdef BOOTH_MUL_EARLY_EXIT_EN
            else if (w_exit) begin
                {w_acc_nx, w_q_nx, w_qm1_nx} = w_jump;
                w_cnt_nx   = '0;
                w_prod_nx  = w_jump[2*WIDTH:1];
                w_state_nx = DONE;
            end
`endif
            else begin
                {w_acc_nx, w_q_nx, w_qm1_nx} = w_step;
                w_cnt_nx = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_prod_nx  = w_step[2*WIDTH:1];
                    w_state_nx = DONE;
                end
            end
        end else if (r_state == DONE) begin
            w_state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
            r_prod  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_acc   <= w_acc_nx;
            r_m     <= w_m_nx;
            r_q     <= w_q_nx;
            r_qm1   <= w_qm1_nx;
            r_cnt   <= w_cnt_nx;
            r_prod  <= w_prod_nx;
        end
    end
endmodule

// File: tb/tb_booth_mul_seq_16.sv
// tb_booth_mul_seq_16: directed vector table plus hand-written multi-cycle sequences.
module tb_booth_mul_seq_16;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cancel = 1'b0;
    logic [15:0] x_in = '0, y_in = '0;
    logic        busy, done;
    logic [31:0] product;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    booth_mul_seq_16 #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel),
        .x_in(x_in), .y_in(y_in), .busy(busy), .done(done), .product(product)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] p;
        int          lat_ee;
    } vec_t;

    vec_t v[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // start is driven in cycle 0 and sampled at its closing edge; n counts cycles after it
    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          output int dc, output int bc, output int ov, output logic [31:0] p);
        @(negedge clk);
        x_in = x; y_in = y; start = 1'b1;
        dc = -1; bc = 0; ov = 0; p = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
            if (busy && done) ov++;
            if (done) begin
                dc = n;
                p = product;
                break;
            end
        end
    endtask

    int          dc, bc, ov, exp_dc, d1, d2, dones;
    logic [31:0] p, p1, p2, prev;
    logic [15:0] cy;

    initial begin
        v[0] = '{16'd3,    16'd5,    32'h0000000F, 6};
        v[1] = '{16'hFFF9, 16'd6,    32'hFFFFFFD6, 6};
        v[2] = '{16'h8000, 16'h8000, 32'h40000000, 17};
        v[3] = '{16'd1234, 16'd0,    32'h00000000, 2};
        v[4] = '{16'd1,    16'd1,    32'h00000001, 4};
        v[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, 17};
        v[6] = '{16'h8000, 16'h7FFF, 32'hC0008000, 17};
        v[7] = '{16'hFFFF, 16'hFFFF, 32'h00000001, 3};
        v[8] = '{16'd100,  16'hFFFD, 32'hFFFFFED4, 5};
        v[9] = '{16'h1234, 16'h0010, 32'h00012340, 8};

        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_product", product, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
`ifdef BOOTH_MUL_EARLY_EXIT_EN
            exp_dc = v[i].lat_ee;
`else
            exp_dc = 17;
`endif
            run_op(v[i].x, v[i].y, dc, bc, ov, p);
            check($sformatf("vec%0d_product", i), p, v[i].p);
            check($sformatf("vec%0d_done_cycle", i), dc, exp_dc);
            check($sformatf("vec%0d_busy_cycles", i), bc, exp_dc - 1);
            check($sformatf("vec%0d_busy_done_overlap", i), ov, 0);
        end

        // start held through RUN with changing operands, restart in the DONE cycle
`ifdef BOOTH_MUL_EARLY_EXIT_EN
        exp_dc = 6;
`else
        exp_dc = 17;
`endif
        @(negedge clk);
        x_in = 16'd3; y_in = 16'd5; start = 1'b1;
        d1 = -1; d2 = -1; p1 = 'x; p2 = 'x;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (d1 > 0 && n == d1 + 1) begin
                check("held_no_idle_bubble", {31'b0, busy}, 32'd1);
                start = 1'b0;
            end
            if (done && d1 < 0) begin
                d1 = n; p1 = product;
                x_in = 16'hFFF9; y_in = 16'd6;
            end else if (done) begin
                d2 = n; p2 = product;
                break;
            end else if (d1 < 0) begin
                x_in = 16'(n * 37); y_in = 16'(n * 91 + 5);
            end
        end
        check("held_first_product", p1, 32'h0000000F);
        check("held_first_done_cycle", d1, exp_dc);
        check("held_second_product", p2, 32'hFFFFFFD6);
        check("held_second_done_cycle", d2, 2 * exp_dc);

        // cancel mid-RUN: no done, product unchanged
`ifdef BOOTH_MUL_EARLY_EXIT_EN
        cy = 16'h7FFF;
`else
        cy = 16'd5;
`endif
        prev = product;
        @(negedge clk);
        x_in = 16'd3; y_in = cy; start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("cancel_busy_before", {31'b0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy_after", {31'b0, busy}, 32'd0);
        check("cancel_done_after", {31'b0, done}, 32'd0);
        dones = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("cancel_no_done", dones, 0);
        check("cancel_product_kept", product, prev);

        // async reset mid-RUN
        @(negedge clk);
        x_in = 16'd3; y_in = 16'd5; start = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_product", product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd3, 16'd5, dc, bc, ov, p);
        check("post_rst_product", p, 32'h0000000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/booth_mul_seq_16.md
Name: booth_mul_seq_16

Overview:
- Multi-cycle signed radix-2 Booth multiplier. It computes the product for ALU result slot in4 (ALU_sel = 100, Rmul), which is currently tied to 32'b0.
- Sits beside the execute-stage ALU and feeds its result mux. The pipeline control stalls on busy and captures product on done.
- One Booth step per clock replaces the large combinational array multiplier, so the ALU critical path is unchanged.

Parameters:
- WIDTH, 16, operand width in bits. product is 2*WIDTH bits. The internal accumulator is WIDTH+1 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- cancel  input  1  synchronous abort of an operation in flight (pipeline flush).
- x_in  input  WIDTH  multiplicand M, two's complement (ALU operand A[15:0]).
- y_in  input  WIDTH  multiplier Q, two's complement (ALU operand B[15:0]).
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse; product is valid in this cycle.
- product  output  2*WIDTH  signed product; held until the next accepted start.

Behaviour:
- Reset (async): state = IDLE; busy = 0; done = 0; product = 0; acc, Q, q_m1 and count are cleared.
- States: IDLE, RUN, DONE.
- IDLE, start = 1: latch M = x_in and Q = y_in. Set acc = 0, q_m1 = 0, count = WIDTH. Go to RUN.
- RUN, one step per cycle:
  - {Q[0], q_m1} = 01: acc = acc + sext(M).
  - {Q[0], q_m1} = 10: acc = acc - sext(M).
  - 00 or 11: acc unchanged.
  - Then arithmetic right shift of {acc, Q, q_m1} by 1, and count = count - 1.
  - When count reaches 0 after a step: product = {acc, Q}[2*WIDTH-1:0], go to DONE.
- DONE: done = 1 for exactly this cycle.
  - start = 1 here: same operand latch as in IDLE, go to RUN (back-to-back operation, no idle bubble).
  - Otherwise: go to IDLE.
- Latency without the optional feature:
  - start sampled at the end of cycle 0.
  - busy is high in cycles 1..WIDTH.
  - done is high in cycle WIDTH+1 (cycle 17 at default WIDTH).
- start while RUN: ignored. Operands are not relatched and the result is unaffected.
- cancel in RUN: go to IDLE next edge. No done pulse; product keeps its previous value.
- cancel in IDLE or DONE: no effect. cancel takes priority over start in the same cycle.
- Arithmetic width: acc is WIDTH+1 bits, so the most negative operand does not overflow. (-2^15) * (-2^15) = 0x4000_0000 exactly.
- No overflow output: every WIDTH x WIDTH signed product fits in 2*WIDTH bits.
- Async reset mid-operation aborts immediately: outputs return to reset values and no done is issued.
- busy and done are never high in the same cycle.

Optional Feature:
- Macro: BOOTH_MUL_EARLY_EXIT_EN.
- Defined: at the start of each RUN cycle, with r = count, check whether Q[r-1:0] are all equal to q_m1.
  - If they are, every remaining step is a pure shift. This cycle performs an arithmetic right shift of {acc, Q, q_m1} by r, loads product, and goes to DONE.
  - Otherwise a normal step is performed.
  - Latency becomes data-dependent: minimum 1 busy cycle, maximum WIDTH. The product value is identical to the non-EN build.
- Undefined: fixed WIDTH-cycle latency as above. The early-exit compare and barrel shift logic is not built.

Test Plan:
- x_in = 3, y_in = 5, start pulse in cycle 0 -> busy cycles 1-16, done in cycle 17, product = 0x0000000F.
- x_in = 0xFFF9 (-7), y_in = 6 -> product = 0xFFFFFFD6 (-42). Also x_in = 0x8000, y_in = 0x8000 -> product = 0x40000000.
- start held high through the whole RUN with changing operands, and a new start in the DONE cycle:
  - the first result is unaffected;
  - the second operation begins with no IDLE cycle and its done arrives 17 cycles after the first.
- cancel in cycle 8 of a 3*5 operation -> IDLE next cycle, no done, product keeps its previous value. rst asserted mid-RUN -> busy = 0, done = 0, product = 0 immediately.
- With BOOTH_MUL_EARLY_EXIT_EN:
  - x_in = 1234, y_in = 0 -> busy 1 cycle, done in cycle 2, product = 0.
  - x_in = 1, y_in = 1 -> busy 3 cycles, done in cycle 4, product = 1.
  - Without the macro, both cases give done in cycle 17 with the same product values.
